sr_fifo_tx: RTL and testbench

Reader end of the CPU data FIFO. The CPU pushes 32-bit register values into `sr_fifo`; this block pops them from the FIFO's read side and serialises each word onto a byte-wide valid/ready output stream, for example towards a UART or debug link. It owns the FIFO read strobe, captures the popped word, and sends it one byte per accepted handshake, flagging the last byte of every word.

---
 rtl/sr_fifo_tx_pkg.sv | 14 +
 rtl/sr_fifo_tx.sv | 109 ++++++++++
 tb/tb_sr_fifo_tx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sr_fifo_tx_pkg.sv
// Shared definitions for the CPU data FIFO reader: state encoding and the
// byte-counter width helper.
package sr_fifo_tx_pkg;

  localparam logic [1:0] FTX_IDLE  = 2'd0;
  localparam logic [1:0] FTX_FETCH = 2'd1;
  localparam logic [1:0] FTX_SEND  = 2'd2;

  // Byte counter needs at least one bit even for single-byte words.
  function automatic int cnt_width(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/sr_fifo_tx.sv
// Pops words from the read side of sr_fifo and serialises each one onto a
// byte-wide valid/ready stream, flagging the last byte of every word.
module sr_fifo_tx
  import sr_fifo_tx_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH = 32,
  parameter bit LSB_FIRST       = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fifoEmpty,
  output logic                       fifoPop,
  input  logic [FIFO_DATA_WIDTH-1:0] fifoData,
  output logic                       txValid,
  input  logic                       txReady,
  output logic [7:0]                 txData,
  output logic                       txLast,
  output logic                       busy
);

  localparam int BYTES = FIFO_DATA_WIDTH / 8;
  localparam int CW    = cnt_width(BYTES);
  localparam logic [CW-1:0] LAST_CNT = CW'(BYTES - 1);

  logic [1:0]                 state_r;
  logic [1:0]                 state_nxt_s;
  logic [FIFO_DATA_WIDTH-1:0] shreg_r;
  logic [CW-1:0]              cnt_r;
  logic                       xfer_s;
  logic                       last_s;

  // Next-state logic; the pop strobe is gated by reset so a word is never
  // drawn from the FIFO while this block cannot capture it.
  always_comb begin
    xfer_s      = (state_r == FTX_SEND) && txReady;
    last_s      = (state_r == FTX_SEND) && (cnt_r == LAST_CNT);
    fifoPop     = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      FTX_IDLE: begin
        fifoPop     = rst_n && !fifoEmpty;
        state_nxt_s = fifoEmpty ? FTX_IDLE : FTX_FETCH;
      end
      FTX_FETCH: begin
        state_nxt_s = FTX_SEND;
      end
      FTX_SEND: begin
        if (xfer_s && last_s) begin
          fifoPop     = rst_n && !fifoEmpty;
          state_nxt_s = fifoEmpty ? FTX_IDLE : FTX_FETCH;
        end else begin
          state_nxt_s = FTX_SEND;
        end
      end
      default: begin
        state_nxt_s = FTX_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FTX_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Shift register: load on FETCH, move the next byte to the output end on
  // every accepted non-final byte, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r <= '0;
    end else if (state_r == FTX_FETCH) begin
      shreg_r <= fifoData;
    end else if (xfer_s && !last_s) begin
      shreg_r <= LSB_FIRST ? (shreg_r >> 8) : (shreg_r << 8);
    end else begin
      shreg_r <= shreg_r;
    end
  end

  // Byte counter within the current word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (state_r == FTX_FETCH) begin
      cnt_r <= '0;
    end else if (xfer_s && !last_s) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Output decode straight from registered state and data.
  always_comb begin
    txValid = (state_r == FTX_SEND);
    busy    = (state_r == FTX_FETCH) || (state_r == FTX_SEND);
    txLast  = last_s;
    if (LSB_FIRST) begin
      txData = shreg_r[7:0];
    end else begin
      txData = shreg_r[FIFO_DATA_WIDTH-1 -: 8];
    end
  end

endmodule

// File: tb/tb_sr_fifo_tx.sv
// Directed bench for sr_fifo_tx: one LSB-first and one MSB-first instance
// fed from a shared FIFO model, checked cycle by cycle against a vector table.
module tb_sr_fifo_tx;

  logic        clk;
  logic        rst_n;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        tx_ready;
  logic        pop0, pop1;
  logic        valid0, valid1;
  logic [7:0]  data0, data1;
  logic        last0, last1;
  logic        busy0, busy1;

  logic [31:0] mem [0:15];
  int          wp;
  int          rp = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  typedef struct {
    bit          push;
    logic [31:0] word;
    logic        ready;
    logic        pop;
    logic        valid;
    logic        busy;
    logic        last;
    logic [7:0]  d_lsb;
    logic [7:0]  d_msb;
  } vec_t;

  vec_t vecs[$];

  sr_fifo_tx #(.FIFO_DATA_WIDTH(32), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .fifoEmpty(fifo_empty), .fifoPop(pop0),
    .fifoData(fifo_data), .txValid(valid0), .txReady(tx_ready),
    .txData(data0), .txLast(last0), .busy(busy0)
  );

  sr_fifo_tx #(.FIFO_DATA_WIDTH(32), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .fifoEmpty(fifo_empty), .fifoPop(pop1),
    .fifoData(fifo_data), .txValid(valid1), .txReady(tx_ready),
    .txData(data1), .txLast(last1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: read data appears the cycle after the pop.
  assign fifo_empty = (wp == rp);
  always @(posedge clk) begin
    if (pop0) begin
      fifo_data <= mem[rp[3:0]];
      rp        <= rp + 1;
    end
  end

  task automatic push(input logic [31:0] w);
    mem[wp[3:0]] = w;
    wp = wp + 1;
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got 0x%0h, expected 0x%0h", name, row, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit push, input logic [31:0] word, input logic ready,
                              input logic pop, input logic valid, input logic busy,
                              input logic last, input logic [7:0] dl, input logic [7:0] dm);
    vec_t v;
    v.push = push; v.word = word; v.ready = ready; v.pop = pop; v.valid = valid;
    v.busy = busy; v.last = last; v.d_lsb = dl; v.d_msb = dm;
    return v;
  endfunction

  // Apply one cycle: called just after a falling edge, ends on the next one.
  task automatic step(input vec_t v, input int row);
    if (v.push) push(v.word);
    tx_ready = v.ready;
    #1;
    chk("pop_lsb", row, {31'd0, pop0}, {31'd0, v.pop});
    chk("pop_msb", row, {31'd0, pop1}, {31'd0, v.pop});
    chk("valid_lsb", row, {31'd0, valid0}, {31'd0, v.valid});
    chk("valid_msb", row, {31'd0, valid1}, {31'd0, v.valid});
    chk("busy_lsb", row, {31'd0, busy0}, {31'd0, v.busy});
    chk("busy_msb", row, {31'd0, busy1}, {31'd0, v.busy});
    chk("last_lsb", row, {31'd0, last0}, {31'd0, v.last});
    chk("last_msb", row, {31'd0, last1}, {31'd0, v.last});
    if (v.valid) begin
      chk("data_lsb", row, {24'd0, data0}, {24'd0, v.d_lsb});
      chk("data_msb", row, {24'd0, data1}, {24'd0, v.d_msb});
    end
    @(negedge clk);
  endtask

  task automatic chk_reset(input int row);
    chk("rst_pop", row, {30'd0, pop0, pop1}, 32'd0);
    chk("rst_valid", row, {30'd0, valid0, valid1}, 32'd0);
    chk("rst_busy", row, {30'd0, busy0, busy1}, 32'd0);
    chk("rst_last", row, {30'd0, last0, last1}, 32'd0);
    chk("rst_data", row, {16'd0, data0, data1}, 32'd0);
  endtask

  initial begin
    wp       = 0;
    rst_n    = 1'b0;
    tx_ready = 1'b0;

    // Single word, ready held high.
    vecs.push_back(mk(1, 32'h11223344, 1, 1, 0, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 32'h0, 1, 0, 0, 1, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 32'h0, 1, 0, 1, 1, 0, 8'h44, 8'h11));
    vecs.push_back(mk(0, 32'h0, 1, 0, 1, 1, 0, 8'h33, 8'h22));
    vecs.push_back(mk(0, 32'h0, 1, 0, 1, 1, 0, 8'h22, 8'h33));
    vecs.push_back(mk(0, 32'h0, 1, 0, 1, 1, 1, 8'h11, 8'h44));
    vecs.push_back(mk(0, 32'h0, 1, 0, 0, 0, 0, 8'h00, 8'h00));
    // Back-to-back words: second pop coincides with the last-byte transfer.
    vecs.push_back(mk(1, 32'hAABBCCDD, 1, 1, 0, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(1, 32'h01020304, 1, 0, 0, 1, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 32'h0, 1, 0, 1, 1, 0, 8'hDD, 8'hAA));
    vecs.push_back(mk(0, 32'h0, 1, 0, 1, 1, 0, 8'hCC, 8'hBB));
    vecs.push_back(mk(0, 32'h0, 1, 0, 1, 1, 0, 8'hBB, 8'hCC));
    vecs.push_back(mk(0, 32'h0, 1, 1, 1, 1, 1, 8'hAA, 8'hDD));
    vecs.push_back(mk(0, 32'h0, 1, 0, 0, 1, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 32'h0, 1, 0, 1, 1, 0, 8'h04, 8'h01));
    vecs.push_back(mk(0, 32'h0, 1, 0, 1, 1, 0, 8'h03, 8'h02));
    vecs.push_back(mk(0, 32'h0, 1, 0, 1, 1, 0, 8'h02, 8'h03));
    vecs.push_back(mk(0, 32'h0, 1, 0, 1, 1, 1, 8'h01, 8'h04));
    vecs.push_back(mk(0, 32'h0, 1, 0, 0, 0, 0, 8'h00, 8'h00));
    // Backpressure on the second byte for three cycles.
    vecs.push_back(mk(1, 32'h11223344, 1, 1, 0, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 32'h0, 1, 0, 0, 1, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 32'h0, 1, 0, 1, 1, 0, 8'h44, 8'h11));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 32'h0, 0, 0, 1, 1, 0, 8'h33, 8'h22));
    vecs.push_back(mk(0, 32'h0, 1, 0, 1, 1, 0, 8'h33, 8'h22));
    vecs.push_back(mk(0, 32'h0, 1, 0, 1, 1, 0, 8'h22, 8'h33));
    vecs.push_back(mk(0, 32'h0, 0, 0, 1, 1, 1, 8'h11, 8'h44));
    vecs.push_back(mk(0, 32'h0, 1, 0, 1, 1, 1, 8'h11, 8'h44));
    // Empty FIFO: nothing moves regardless of ready.
    for (int i = 0; i < 20; i++)
      vecs.push_back(mk(0, 32'h0, logic'(i % 2), 0, 0, 0, 0, 8'h00, 8'h00));

    #3;
    chk_reset(-1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i], i);

    // Reset mid-word after byte 0x33 was accepted; the next word starts clean.
    push(32'h11223344);
    push(32'h55667788);
    step(mk(0, 32'h0, 1, 1, 0, 0, 0, 8'h00, 8'h00), 100);
    step(mk(0, 32'h0, 1, 0, 0, 1, 0, 8'h00, 8'h00), 101);
    step(mk(0, 32'h0, 1, 0, 1, 1, 0, 8'h44, 8'h11), 102);
    step(mk(0, 32'h0, 1, 0, 1, 1, 0, 8'h33, 8'h22), 103);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset(104);
    @(negedge clk);
    chk_reset(105);
    rst_n = 1'b1;
    step(mk(0, 32'h0, 1, 1, 0, 0, 0, 8'h00, 8'h00), 106);
    step(mk(0, 32'h0, 1, 0, 0, 1, 0, 8'h00, 8'h00), 107);
    step(mk(0, 32'h0, 1, 0, 1, 1, 0, 8'h88, 8'h55), 108);
    step(mk(0, 32'h0, 1, 0, 1, 1, 0, 8'h77, 8'h66), 109);
    step(mk(0, 32'h0, 1, 0, 1, 1, 0, 8'h66, 8'h77), 110);
    step(mk(0, 32'h0, 1, 0, 1, 1, 1, 8'h55, 8'h88), 111);
    step(mk(0, 32'h0, 1, 0, 0, 0, 0, 8'h00, 8'h00), 112);
    chk("fifo_drained", 113, rp, wp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
